// File: rtl/regfile_ctx_pkg.sv
// Shared types and widths for the register-file context save/restore engine.
package regfile_ctx_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef enum logic [2:0] {
    IDLE,
    SAVE_RD,
    SAVE_TX,
    RESTORE,
    DONE
  } ctx_state_e;

endpackage

// File: rtl/regfile_context_engine.sv
// Streams registers FIRST_REG..LAST_REG out of the register file (save) or
// writes an incoming stream back into them (restore).
//
// state   | meaning
// IDLE    | ports released, waiting for save_req_i / restore_req_i
// SAVE_RD | read rf[idx] into the output stage
// SAVE_TX | hold the output beat until the sink accepts it
// RESTORE | write each accepted input beat into rf[idx]
// DONE    | one-cycle completion pulse
module regfile_context_engine
  import regfile_ctx_pkg::*;
#(
  parameter int FIRST_REG = 1,
  parameter int LAST_REG  = 31
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  save_req_i,
  input  logic                  restore_req_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [REG_ADDR_W-1:0] rf_read_reg_o,
  input  logic [DATA_W-1:0]     rf_read_data_i,
  output logic                  rf_write_enable_o,
  output logic [REG_ADDR_W-1:0] rf_write_reg_o,
  output logic [DATA_W-1:0]     rf_write_data_o,
  output logic                  m_valid_o,
  output logic [DATA_W-1:0]     m_data_o,
  output logic                  m_last_o,
  input  logic                  m_ready_i,
  input  logic                  s_valid_i,
  input  logic [DATA_W-1:0]     s_data_i,
  input  logic                  s_last_i,
  output logic                  s_ready_o
);

  localparam logic [REG_ADDR_W-1:0] FIRST_IDX = REG_ADDR_W'(FIRST_REG);
  localparam logic [REG_ADDR_W-1:0] LAST_IDX  = REG_ADDR_W'(LAST_REG);

  ctx_state_e            state_q, state_d;
  logic [REG_ADDR_W-1:0] idx_q, idx_d;
  logic                  m_valid_q, m_valid_d;
  logic [DATA_W-1:0]     m_data_q, m_data_d;
  logic                  m_last_q, m_last_d;
  logic                  error_q, error_d;
  logic                  exp_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      error_q   <= error_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    idx_d             = idx_q;
    m_valid_d         = m_valid_q;
    m_data_d          = m_data_q;
    m_last_d          = m_last_q;
    error_d           = error_q;
    exp_last          = 1'b0;
    busy_o            = 1'b0;
    done_o            = 1'b0;
    rf_read_reg_o     = '0;
    rf_write_enable_o = 1'b0;
    rf_write_reg_o    = '0;
    rf_write_data_o   = '0;
    s_ready_o         = 1'b0;

    case (state_q)
      IDLE: begin
        if (save_req_i) begin
          state_d = SAVE_RD;
          idx_d   = FIRST_IDX;
          error_d = 1'b0;
        end else if (restore_req_i) begin
          state_d = RESTORE;
          idx_d   = FIRST_IDX;
          error_d = 1'b0;
        end
      end
      SAVE_RD: begin
        busy_o        = 1'b1;
        rf_read_reg_o = idx_q;
        m_data_d      = rf_read_data_i;
        m_last_d      = (idx_q == LAST_IDX);
        m_valid_d     = 1'b1;
        state_d       = SAVE_TX;
      end
      SAVE_TX: begin
        busy_o = 1'b1;
        if (m_valid_q && m_ready_i) begin
          m_valid_d = 1'b0;
          if (m_last_q) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + REG_ADDR_W'(1);
            state_d = SAVE_RD;
          end
        end
      end
      RESTORE: begin
        busy_o            = 1'b1;
        s_ready_o         = 1'b1;
        rf_write_enable_o = s_valid_i;
        rf_write_reg_o    = idx_q;
        rf_write_data_o   = s_data_i;
        if (s_valid_i) begin
          exp_last = (idx_q == LAST_IDX);
          if (s_last_i != exp_last) error_d = 1'b1;
          // Termination is decided before the increment, so idx never wraps.
          if (s_last_i || exp_last) state_d = DONE;
          else                      idx_d   = idx_q + REG_ADDR_W'(1);
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign m_valid_o = m_valid_q;
  assign m_data_o  = m_data_q;
  assign m_last_o  = m_last_q;
  assign error_o   = error_q;

endmodule

// File: tb/tb_regfile_context_engine.sv
// Randomized bench for regfile_context_engine against a behavioural register
// file and transfer model.
module tb_regfile_context_engine;
  import regfile_ctx_pkg::*;

  localparam int FIRST = 1;
  localparam int LAST  = 31;
  localparam int N     = LAST - FIRST + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        save_req, restore_req;
  logic        busy, done, error;
  logic [4:0]  rf_read_reg;
  logic [31:0] rf_read_data;
  logic        rf_write_enable;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_write_data;
  logic        m_valid, m_last, m_ready;
  logic [31:0] m_data;
  logic        s_valid, s_last, s_ready;
  logic [31:0] s_data;

  logic [31:0] rf [32];
  int n_checks = 0;
  int n_errors = 0;
  int wr_count = 0;
  int wr_outside = 0;
  int wr_r0 = 0;

  regfile_context_engine #(.FIRST_REG(FIRST), .LAST_REG(LAST)) dut (
    .clk               (clk),
    .rst               (rst),
    .save_req_i        (save_req),
    .restore_req_i     (restore_req),
    .busy_o            (busy),
    .done_o            (done),
    .error_o           (error),
    .rf_read_reg_o     (rf_read_reg),
    .rf_read_data_i    (rf_read_data),
    .rf_write_enable_o (rf_write_enable),
    .rf_write_reg_o    (rf_write_reg),
    .rf_write_data_o   (rf_write_data),
    .m_valid_o         (m_valid),
    .m_data_o          (m_data),
    .m_last_o          (m_last),
    .m_ready_i         (m_ready),
    .s_valid_i         (s_valid),
    .s_data_i          (s_data),
    .s_last_i          (s_last),
    .s_ready_o         (s_ready)
  );

  always #5 clk = ~clk;

  assign rf_read_data = rf[rf_read_reg];

  // Register file: r0 is hardwired to zero.
  always @(posedge clk) begin
    if (rf_write_enable) begin
      wr_count = wr_count + 1;
      if (!s_ready) wr_outside = wr_outside + 1;
      if (rf_write_reg == 5'd0) wr_r0 = wr_r0 + 1;
      else rf[rf_write_reg] = rf_write_data;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic recover();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at a negedge with the engine idle.
  task automatic run_save(input bit rnd_ready, input bit both_req, input bit mid_restore, input string tag);
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    int          last_cnt = 0, last_pos = 0, busy_cnt = 0, stall_bad = 0, wr0, idle_busy = 0;
    bit          finished = 0, prev_stall = 0;
    logic [31:0] prev_data = '0;
    for (int r = FIRST; r <= LAST; r++) exp_q.push_back(rf[r]);
    wr0 = wr_count;
    save_req    = 1'b1;
    restore_req = both_req;
    @(negedge clk);
    save_req    = 1'b0;
    restore_req = 1'b0;
    check({tag, "_err_cleared"}, 64'(error), 64'(0));
    check({tag, "_busy_rise"}, 64'(busy), 64'(1));
    for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
      if (done) begin
        finished = 1;
      end else begin
        if (busy) busy_cnt++;
        if (prev_stall && (!m_valid || m_data !== prev_data)) stall_bad++;
        restore_req = mid_restore && (cyc == 5);
        m_ready     = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (m_valid && m_ready) begin
          got_q.push_back(m_data);
          if (m_last) begin
            last_cnt++;
            last_pos = got_q.size();
          end
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        @(negedge clk);
      end
    end
    restore_req = 1'b0;
    m_ready     = 1'b0;
    check({tag, "_done_seen"}, 64'(finished), 64'(1));
    check({tag, "_beats"}, 64'(got_q.size()), 64'(N));
    for (int i = 0; i < N && i < got_q.size(); i++)
      check($sformatf("%s_w%0d", tag, i + FIRST), 64'(got_q[i]), 64'(exp_q[i]));
    check({tag, "_last_cnt"}, 64'(last_cnt), 64'(1));
    check({tag, "_last_pos"}, 64'(last_pos), 64'(N));
    check({tag, "_stall_stable"}, 64'(stall_bad), 64'(0));
    if (!rnd_ready) check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(2 * N));
    check({tag, "_error"}, 64'(error), 64'(0));
    check({tag, "_no_writes"}, 64'(wr_count - wr0), 64'(0));
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 64'(done), 64'(0));
    for (int i = 0; i < 5; i++) begin
      if (busy || rf_read_reg != 5'd0) idle_busy++;
      @(negedge clk);
    end
    check({tag, "_stays_idle"}, 64'(idle_busy), 64'(0));
    if (!finished) recover();
  endtask

  // last_at: 1-based beat carrying s_last; 0 means the sender never asserts it.
  task automatic run_restore(input int last_at, input bit gaps, input logic [31:0] base, input string tag);
    logic [31:0] exp_rf [32];
    int          n_words, k = 0, busy_cnt = 0, gap_cnt = 0, ready_bad = 0;
    bit          finished = 0, exp_err;
    n_words = (last_at == 0 || last_at > N) ? N : last_at;
    exp_err = (last_at != N);
    exp_rf  = rf;
    for (int i = 0; i < n_words; i++) exp_rf[FIRST + i] = base + 32'(FIRST + i);
    restore_req = 1'b1;
    @(negedge clk);
    restore_req = 1'b0;
    for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
      if (done) begin
        finished = 1;
      end else begin
        busy_cnt++;
        if (!s_ready || !busy) ready_bad++;
        if (k < n_words && (!gaps || $urandom_range(0, 2) != 0)) begin
          s_valid = 1'b1;
          s_data  = base + 32'(FIRST + k);
          s_last  = (last_at == k + 1);
          k++;
        end else begin
          s_valid = 1'b0;
          s_data  = 32'($urandom);
          s_last  = 1'($urandom_range(0, 1));
          gap_cnt++;
        end
        @(negedge clk);
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    check({tag, "_done_seen"}, 64'(finished), 64'(1));
    check({tag, "_accepted"}, 64'(k), 64'(n_words));
    check({tag, "_ready"}, 64'(ready_bad), 64'(0));
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(n_words + gap_cnt));
    check({tag, "_error"}, 64'(error), 64'(exp_err));
    for (int r = 0; r < 32; r++)
      check($sformatf("%s_r%0d", tag, r), 64'(rf[r]), 64'(exp_rf[r]));
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 64'(done), 64'(0));
    check({tag, "_error_held"}, 64'(error), 64'(exp_err));
    if (!finished) recover();
  endtask

  initial begin
    int hs;
    save_req    = 1'b0;
    restore_req = 1'b0;
    m_ready     = 1'b0;
    s_valid     = 1'b0;
    s_data      = '0;
    s_last      = 1'b0;
    for (int r = 0; r < 32; r++) rf[r] = (r == 0) ? 32'd0 : 32'h1000_0000 + 32'(r);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_error", 64'(error), 64'(0));
    check("rst_m_valid", 64'(m_valid), 64'(0));
    check("rst_m_data", 64'(m_data), 64'(0));
    check("rst_m_last", 64'(m_last), 64'(0));
    check("rst_s_ready", 64'(s_ready), 64'(0));
    check("rst_rf_we", 64'(rf_write_enable), 64'(0));
    check("rst_rf_rd", 64'(rf_read_reg), 64'(0));

    run_save(1'b0, 1'b0, 1'b0, "save_full");
    run_save(1'b1, 1'b0, 1'b0, "save_bp");
    run_restore(N, 1'b1, 32'hA5A5_0000, "rest_full");
    run_restore(10, 1'b0, 32'h5A5A_0000, "rest_trunc");
    run_save(1'b0, 1'b1, 1'b1, "save_both");

    // Reset while beat 5 of a save is pending.
    save_req = 1'b1;
    @(negedge clk);
    save_req = 1'b0;
    hs = 0;
    for (int cyc = 0; cyc < 200 && hs < 4; cyc++) begin
      m_ready = 1'b1;
      if (m_valid) hs++;
      @(negedge clk);
    end
    m_ready = 1'b0;
    for (int cyc = 0; cyc < 20 && !m_valid; cyc++) @(negedge clk);
    check("mid_beat5_data", 64'(m_data), 64'(rf[FIRST + 4]));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_m_valid", 64'(m_valid), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_done", 64'(done), 64'(0));
    run_save(1'b0, 1'b0, 1'b0, "save_after_rst");

    run_restore(0, 1'b1, 32'h0BAD_0000, "rest_nolast");
    run_restore(1, 1'b0, 32'h0001_0000, "rest_first_only");

    for (int it = 0; it < 4; it++) begin
      int la;
      for (int r = 1; r < 32; r++) rf[r] = $urandom;
      run_save(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $sformatf("rnd%0d_save", it));
      la = (it % 2 == 0) ? N : int'($urandom_range(0, N));
      run_restore(la, 1'b1, $urandom, $sformatf("rnd%0d_rest", it));
      run_save(1'b1, 1'b0, 1'b0, $sformatf("rnd%0d_readback", it));
    end

    check("rf_we_outside_restore", 64'(wr_outside), 64'(0));
    check("rf_we_r0", 64'(wr_r0), 64'(0));
    check("r0_zero", 64'(rf[0]), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
